sfx_beep_arbiter: RTL and testbench
===================================

# sfx_beep_arbiter

Owns the single buzzer pin and shares it between background music and game sound effects (hit, miss, level-up, game-over). The music sequencer's raw `beep_out` passes through while no effect is active. An effect request mutes the music and plays a short fixed tone sequence from a constant table. Higher-priority effects pre-empt lower ones. The block sits between the music sequencer, the game FSM and the top-level buzzer pin.

## Interface
Parameters:
- `MS_CYCLES`, default 50_000: clock cycles per millisecond (50 MHz). Benches override it to 10.
- `GAP_MS`, default 5: silence after each effect, in ms.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low. This is the single clock/reset domain.
- `music_beep` in 1: square wave from the music sequencer.
- `music_en` in 1: music enabled; gates `music_beep`.
- `sfx_req` in 4: one-cycle request pulses. Bit i requests effect i; id 3 has the highest priority.
- `beep_out` out 1: registered buzzer drive.
- `music_mute` out 1: high while an effect owns the buzzer. The music sequencer may pause on it.
- `sfx_busy` out 1: high in states other than IDLE.
- `sfx_id` out 2: id of the effect playing or last played.
- `drop_cnt` out 8: count of discarded requests; saturates at 255.

## Operation
- Effect table. Each step is given as (half-period in cycles, duration in ms).
  - id0 HIT: (31887, 50), (23855, 50).
  - id1 MISS: (75758, 100), (95420, 150).
  - id2 LEVEL: (47710, 80), (37879, 80), (31888, 80).
  - id3 OVER: (63776, 150), (75758, 150), (95420, 150), (127551, 300).
  - A half-period of 0 means a rest: output 0 for that step.
- Request capture. `pend[i]` is set by `sfx_req[i]` in any state. If `pend[i]` is already set, the request is dropped and `drop_cnt` increments.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: if `pend` is non-zero, latch the highest set id into `sfx_id`, clear that pend bit, and go to LOAD.
  - LOAD: step index = 0; load the half-period and duration; clear the tone counter, phase, ms prescaler and ms counter; go to PLAY.
  - PLAY: produce a square wave. The phase toggles when the tone counter reaches half−1, and the counter then wraps to 0. The ms prescaler wraps at MS_CYCLES−1 and increments the ms counter. When the ms counter equals the duration on a prescaler wrap, the step ends.
    - If another step remains: advance the step index and go back to LOAD.
    - If it was the last step: go to GAP.
  - Pre-emption: in PLAY or GAP, a pend bit with an id strictly greater than `sfx_id` aborts the current effect. The FSM latches the new id, clears its pend bit, and goes to LOAD on the next cycle. The aborted effect is counted in `drop_cnt`.
  - GAP: silence for GAP_MS ms. Then go to IDLE if `pend` is 0; otherwise select the next effect directly, as IDLE would.
- Output selection:
  - `beep_out` = `music_beep & music_en` in IDLE.
  - `beep_out` = tone phase in PLAY.
  - `beep_out` = 0 in LOAD and GAP.
- `music_mute` = 1 in LOAD, PLAY and GAP.
- `drop_cnt` gets at most +1 per cycle. If an abort and a drop occur in the same cycle, it counts +1 and the extra event is lost; this is documented behaviour.

## Timing
- Reset values: `beep_out` 0, `music_mute` 0, `sfx_busy` 0, `sfx_id` 0, `drop_cnt` 0, `pend` 0, FSM in IDLE.
- Reset asserted mid-effect silences the buzzer immediately and discards all pending requests.
- Request to first tone edge: `sfx_req` at cycle t, then pend at t+1, IDLE decides at t+1, LOAD at t+2, PLAY at t+3. `beep_out` is registered, so the first high appears at t+3+half+1.
- A step lasts exactly duration×MS_CYCLES cycles in PLAY, plus 1 LOAD cycle.
- A request in the same cycle as its own effect ending is captured in pend. It is served after GAP with no loss.
- Simultaneous requests are all captured. They are served highest id first; the lower ones remain pending.
- Tone counter width 17 bits, ms counter 9 bits, prescaler 16 bits.

## Structure
- `sfx_pkg` holds:
  - the FSM state enum;
  - the effect id constants;
  - the step-count array;
  - the half-period and duration step table, flattened as id×4+step.
- Sub-module `sfx_tone_gen` contains the half-period counter and phase register. It has a synchronous clear input and a half-period input; a half-period of 0 forces the output to 0.

## Test plan
Sim runs with MS_CYCLES=10 and GAP_MS=5.
- Music pass-through: `music_en`=1, `music_beep` toggling, no requests. `beep_out` follows `music_beep` with 1-cycle delay; `music_mute`=0.
- HIT request: pulse `sfx_req`=4'b0001. Expect:
  - `music_mute` high from t+2;
  - 500 PLAY cycles at half 31887;
  - then 500 at 23855;
  - GAP of 50 cycles;
  - `music_mute` low and pass-through restored.
- Pre-emption: start MISS, then pulse OVER 200 cycles later. Expect:
  - LOAD on the cycle after pend sets;
  - `sfx_id`=3;
  - `drop_cnt`=1;
  - the MISS wave stops.
- Queueing: pulse `sfx_req`=4'b0101 together. Expect LEVEL first, then GAP, then HIT; `drop_cnt` stays 0.
- Duplicate drop: during a playing OVER effect, pulse HIT twice. `drop_cnt`=1 and HIT plays once after OVER.
- Reset mid-effect: assert `rst_n`=0 during PLAY. All outputs read 0 asynchronously; after release the block is in IDLE with pend 0.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared types and constant tone tables for the buzzer arbiter.
// Step tables are flattened as {id, step}; unused slots are zero.
package sfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } sfx_state_t;

  localparam logic [1:0] SFX_HIT   = 2'd0;
  localparam logic [1:0] SFX_MISS  = 2'd1;
  localparam logic [1:0] SFX_LEVEL = 2'd2;
  localparam logic [1:0] SFX_OVER  = 2'd3;

  localparam int unsigned HALF_W  = 17;
  localparam int unsigned MS_W    = 9;
  localparam int unsigned PRESC_W = 16;

  // Number of steps per effect, indexed by id.
  localparam logic [3:0][2:0] STEP_CNT = {3'd4, 3'd3, 3'd2, 3'd2};

  localparam logic [15:0][HALF_W-1:0] HALF_TBL = {
    17'd127551, 17'd95420, 17'd75758, 17'd63776,
    17'd0,      17'd31888, 17'd37879, 17'd47710,
    17'd0,      17'd0,     17'd95420, 17'd75758,
    17'd0,      17'd0,     17'd23855, 17'd31887
  };

  localparam logic [15:0][MS_W-1:0] DUR_TBL = {
    9'd300, 9'd150, 9'd150, 9'd150,
    9'd0,   9'd80,  9'd80,  9'd80,
    9'd0,   9'd0,   9'd150, 9'd100,
    9'd0,   9'd0,   9'd50,  9'd50
  };

  function automatic logic [1:0] top_id(input logic [3:0] p);
    if (p[3])      return 2'd3;
    else if (p[2]) return 2'd2;
    else if (p[1]) return 2'd1;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: phase flips every `half` enabled cycles.
// A half-period of zero is a rest and holds the output low.
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [HALF_W-1:0] half,
  output logic              tone
);

  logic [HALF_W-1:0] cnt;
  logic              phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (half == '0) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == half - 17'd1) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 17'd1;
      end
    end
  end

  assign tone = phase & (half != '0);

endmodule

// File: rtl/sfx_beep_arbiter.sv
// Shares the buzzer between music pass-through and prioritised sound effects.
// Effects mute the music, play a constant tone table, then hold a short gap.
module sfx_beep_arbiter
  import sfx_pkg::*;
#(
  parameter int unsigned MS_CYCLES = 50_000,
  parameter int unsigned GAP_MS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       music_beep,
  input  logic       music_en,
  input  logic [3:0] sfx_req,
  output logic       beep_out,
  output logic       music_mute,
  output logic       sfx_busy,
  output logic [1:0] sfx_id,
  output logic [7:0] drop_cnt
);

  sfx_state_t         state, state_d;
  logic [3:0]         pend;
  logic [1:0]         step;
  logic [HALF_W-1:0]  half_r;
  logic [MS_W-1:0]    dur_r;
  logic [PRESC_W-1:0] presc;
  logic [MS_W-1:0]    ms_cnt;

  logic       tone;
  logic       take, abort, adv;
  logic [1:0] sel_id;
  logic [3:0] clr_mask;
  logic       preempt, presc_wrap, step_end, gap_end, last_step, drop_any;
  logic       beep_d;

  assign sel_id     = top_id(pend);
  assign preempt    = (|pend) && (sel_id > sfx_id);
  assign presc_wrap = (presc == PRESC_W'(MS_CYCLES - 1));
  // Compare against duration-1 so a step spans exactly duration*MS_CYCLES cycles.
  assign step_end   = presc_wrap && (ms_cnt == dur_r - 9'd1);
  assign gap_end    = presc_wrap && (ms_cnt == MS_W'(GAP_MS - 1));
  assign last_step  = (step == 2'(STEP_CNT[sfx_id] - 3'd1));
  assign drop_any   = |(sfx_req & pend);
  assign clr_mask   = take ? (4'b0001 << sel_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    take    = 1'b0;
    abort   = 1'b0;
    adv     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          take    = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_PLAY;
      ST_PLAY: begin
        if (preempt) begin
          take    = 1'b1;
          abort   = 1'b1;
          state_d = ST_LOAD;
        end else if (step_end) begin
          if (last_step) begin
            state_d = ST_GAP;
          end else begin
            adv     = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (preempt) begin
          take    = 1'b1;
          abort   = 1'b1;
          state_d = ST_LOAD;
        end else if (gap_end) begin
          if (|pend) begin
            take    = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beep_d     = 1'b0;
    music_mute = 1'b0;
    sfx_busy   = 1'b0;
    case (state)
      ST_IDLE: beep_d = music_beep & music_en;
      ST_PLAY: begin
        beep_d     = tone;
        music_mute = 1'b1;
        sfx_busy   = 1'b1;
      end
      default: begin
        music_mute = 1'b1;
        sfx_busy   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_out <= 1'b0;
      pend     <= '0;
      sfx_id   <= '0;
      step     <= '0;
      half_r   <= '0;
      dur_r    <= '0;
      presc    <= '0;
      ms_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      beep_out <= beep_d;
      // A request whose pend bit is already set is discarded, not re-armed.
      pend     <= (pend & ~clr_mask) | (sfx_req & ~pend);

      if (take) begin
        sfx_id <= sel_id;
        step   <= '0;
      end else if (adv) begin
        step <= step + 2'd1;
      end

      if (state == ST_LOAD) begin
        half_r <= HALF_TBL[{sfx_id, step}];
        dur_r  <= DUR_TBL[{sfx_id, step}];
      end

      if (state_d != state) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (state == ST_PLAY || state == ST_GAP) begin
        if (presc_wrap) begin
          presc  <= '0;
          ms_cnt <= ms_cnt + 9'd1;
        end else begin
          presc <= presc + 16'd1;
        end
      end

      if ((drop_any || abort) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  sfx_tone_gen u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_LOAD),
    .en    (state == ST_PLAY),
    .half  (half_r),
    .tone  (tone)
  );

endmodule

// File: tb/tb_sfx_beep_arbiter.sv
// Directed bench for sfx_beep_arbiter with a scoreboard of expected effect starts.
module tb_sfx_beep_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       music_beep = 1'b0;
  logic       music_en = 1'b0;
  logic [3:0] sfx_req = '0;
  logic       beep_out, music_mute, sfx_busy;
  logic [1:0] sfx_id;
  logic [7:0] drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sfx_beep_arbiter #(.MS_CYCLES(10), .GAP_MS(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .music_beep (music_beep),
    .music_en   (music_en),
    .sfx_req    (sfx_req),
    .beep_out   (beep_out),
    .music_mute (music_mute),
    .sfx_busy   (sfx_busy),
    .sfx_id     (sfx_id),
    .drop_cnt   (drop_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] r);
    sfx_req = r;
    tick(1);
    sfx_req = '0;
  endtask

  // Cycles spent with music muted from now on, and how often the buzzer went high meanwhile.
  task automatic measure(output int n, output int hi);
    n  = 0;
    hi = 0;
    while (music_mute === 1'b1 && n < 20000) begin
      music_beep = ~music_beep;
      tick(1);
      n++;
      if (music_mute === 1'b1 && beep_out !== 1'b0) hi++;
    end
  endtask

  // Effect start = mute rising, or the effect id changing while still muted.
  logic       prev_mute = 1'b0;
  logic [1:0] prev_id = '0;
  always @(negedge clk) begin
    if (music_mute === 1'b1 && (prev_mute !== 1'b1 || sfx_id !== prev_id)) begin
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4;
      chk("sb_start_id", 32'(sfx_id), 32'(e));
    end
    prev_mute = music_mute;
    prev_id   = sfx_id;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi;
    logic expb;

    // Reset state
    tick(3);
    chk("rst_beep", 32'(beep_out), 0);
    chk("rst_mute", 32'(music_mute), 0);
    chk("rst_busy", 32'(sfx_busy), 0);
    chk("rst_id", 32'(sfx_id), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    tick(2);

    // Music pass-through, one-cycle delay, gated by music_en
    for (int i = 0; i < 20; i++) begin
      music_en   = (i < 14);
      music_beep = 1'($urandom_range(0, 1));
      expb       = music_beep & music_en;
      tick(1);
      chk("pass_beep", 32'(beep_out), 32'(expb));
      chk("pass_mute", 32'(music_mute), 0);
    end

    // HIT: two 500-cycle steps, 50-cycle gap
    music_en = 1'b1;
    exp_q.push_back(0);
    pulse(4'b0001);
    chk("hit_mute_t1", 32'(music_mute), 0);
    tick(1);
    chk("hit_mute_t2", 32'(music_mute), 1);
    chk("hit_busy", 32'(sfx_busy), 1);
    chk("hit_id", 32'(sfx_id), 0);
    measure(n, hi);
    chk("hit_len", 32'(n), 1052);
    chk("hit_muted", 32'(hi), 0);
    chk("hit_busy_end", 32'(sfx_busy), 0);
    music_beep = 1'b1;
    tick(1);
    chk("hit_restore1", 32'(beep_out), 1);
    music_beep = 1'b0;
    tick(1);
    chk("hit_restore0", 32'(beep_out), 0);

    // Queueing: LEVEL then HIT back to back, nothing dropped
    exp_q.push_back(2);
    exp_q.push_back(0);
    pulse(4'b0101);
    tick(1);
    chk("q_id", 32'(sfx_id), 2);
    measure(n, hi);
    chk("q_len", 32'(n), 3505);
    chk("q_muted", 32'(hi), 0);
    chk("q_drop", 32'(drop_cnt), 0);

    // Pre-emption: OVER aborts MISS 200 cycles in
    exp_q.push_back(1);
    pulse(4'b0010);
    tick(1);
    chk("pre_id_miss", 32'(sfx_id), 1);
    tick(200);
    chk("pre_drop0", 32'(drop_cnt), 0);
    exp_q.push_back(3);
    pulse(4'b1000);
    chk("pre_id_hold", 32'(sfx_id), 1);
    tick(1);
    chk("pre_id_over", 32'(sfx_id), 3);
    chk("pre_drop1", 32'(drop_cnt), 1);
    measure(n, hi);
    chk("pre_len", 32'(n), 7554);
    chk("pre_muted", 32'(hi), 0);

    // Reset mid-effect with a request pending
    exp_q.push_back(2);
    pulse(4'b0100);
    tick(50);
    pulse(4'b0001);
    tick(10);
    chk("rm_id_pre", 32'(sfx_id), 2);
    chk("rm_busy_pre", 32'(sfx_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_beep", 32'(beep_out), 0);
    chk("rm_mute", 32'(music_mute), 0);
    chk("rm_busy", 32'(sfx_busy), 0);
    chk("rm_id", 32'(sfx_id), 0);
    chk("rm_drop", 32'(drop_cnt), 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("rm_idle_busy", 32'(sfx_busy), 0);
    chk("rm_idle_mute", 32'(music_mute), 0);

    // Duplicate HIT during OVER: one dropped, HIT served once afterwards
    exp_q.push_back(3);
    exp_q.push_back(0);
    pulse(4'b1000);
    tick(1);
    chk("dup_id", 32'(sfx_id), 3);
    tick(100);
    pulse(4'b0001);
    tick(5);
    pulse(4'b0001);
    chk("dup_drop", 32'(drop_cnt), 1);
    chk("dup_id_keep", 32'(sfx_id), 3);
    measure(n, hi);
    chk("dup_len", 32'(n), 8499);
    chk("dup_muted", 32'(hi), 0);
    chk("dup_drop_end", 32'(drop_cnt), 1);

    tick(2);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
